// File: rtl/jk_seq_pkg.sv
// Shared definitions for the JK count sequencer: command opcodes and FSM states.
package jk_seq_pkg;

  // Command opcodes carried on cmd_op
  typedef enum logic [1:0] {
    CLEAR = 2'b00,
    LOAD  = 2'b01,
    UP    = 2'b10,
    DOWN  = 2'b11
  } op_e;

  // Sequencer FSM state encodings
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/jk_bank.sv
// Bank of WIDTH behavioural JK flip-flops with a shared clock and async active-low reset.
// Purely storage: every bit follows its own J/K pair, no sequencing lives here.
module jk_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  // JK characteristic per bit: 00 hold, 01 reset, 10 set, 11 toggle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else begin
      q <= (j & ~q) | (~k & q);
    end
  end

endmodule

// File: rtl/jk_count_sequencer.sv
// Command-driven modulo-MOD counter built on a JK flop bank.
// Accepts CLEAR / LOAD / UP n / DOWN n commands through a valid/ready handshake
// and drives the flops only through per-bit J/K.
// Optional feature: define JK_SEQ_WRAP_FLAG_EN to add the sticky wrap_flag output.
module jk_count_sequencer
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc
`ifdef JK_SEQ_WRAP_FLAG_EN
  ,
  output logic             wrap_flag
`endif
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_e           state;
  op_e              op_q;
  logic [WIDTH-1:0] data_q;

  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] up_next;
  logic [WIDTH-1:0] down_next;
  logic [WIDTH-1:0] step_next;
  logic             is_step_op;
  logic             step_en;
  logic             exec_last;
  logic             wrap_now;

  jk_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clk(clk),
    .rst(rst),
    .j  (j),
    .k  (k),
    .q  (count)
  );

  assign tc = (count == MAX_VAL);

  // Next-count arithmetic, step qualification and end-of-command detection
  always_comb begin
    load_val   = (data_q > MAX_VAL) ? MAX_VAL : data_q;
    up_next    = (count == MAX_VAL) ? '0 : count + ONE;
    down_next  = (count == '0) ? MAX_VAL : count - ONE;
    is_step_op = (op_q == UP) || (op_q == DOWN);
    step_next  = (op_q == UP) ? up_next : down_next;
    step_en    = (state == EXEC) && is_step_op && (data_q != '0);
    exec_last  = !is_step_op || (data_q <= ONE);
    wrap_now   = step_en && (((op_q == UP) && (count == MAX_VAL)) ||
                             ((op_q == DOWN) && (count == '0)));
  end

  // J/K derivation for the flop bank; hold everywhere except in EXEC
  always_comb begin
    j = '0;
    k = '0;
    if (state == EXEC) begin
      case (op_q)
        CLEAR: begin
          k = '1;
        end
        LOAD: begin
          j = load_val;
          k = ~load_val;
        end
        default: begin
          if (step_en) begin
            j = count ^ step_next;
            k = count ^ step_next;
          end
        end
      endcase
    end
  end

  // Command FSM with registered handshake/status outputs; data_q doubles as the remaining-step counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      op_q      <= CLEAR;
      data_q    <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state     <= EXEC;
            op_q      <= op_e'(cmd_op);
            data_q    <= cmd_data;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        EXEC: begin
          if (step_en) begin
            data_q <= data_q - ONE;
          end
          if (exec_last) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef JK_SEQ_WRAP_FLAG_EN
  // Sticky wrap indicator: set by any counting wrap, cleared only by CLEAR or reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_flag <= 1'b0;
    end else if ((state == EXEC) && (op_q == CLEAR)) begin
      wrap_flag <= 1'b0;
    end else if (wrap_now) begin
      wrap_flag <= 1'b1;
    end
  end
`else
  logic unused_wrap;
  assign unused_wrap = wrap_now;
`endif

endmodule

// File: tb/tb_jk_count_sequencer.sv
// Self-checking bench for jk_count_sequencer (WIDTH=4, MOD=10).
// Table-driven commands with a scoreboard of expected final counts, plus
// hand-written sequences for per-step timing and reset during a command.
module tb_jk_count_sequencer;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_UP    = 2'b10;
  localparam logic [1:0] OP_DOWN  = 2'b11;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic       tc;
`ifdef JK_SEQ_WRAP_FLAG_EN
  logic       wrap_flag;
`endif

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [3:0] expCount;
    logic       expTc;
    int         expBusy;
    logic       expWrap;
  } vec_t;

  typedef struct {
    logic [3:0] count;
    logic       tc;
  } exp_t;

  exp_t expQ[$];
  vec_t vecs[12];
  int   checks;
  int   failures;

  jk_count_sequencer #(
    .WIDTH(4),
    .MOD  (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .tc       (tc)
`ifdef JK_SEQ_WRAP_FLAG_EN
    ,
    .wrap_flag(wrap_flag)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expectation
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Follow a running command until busy drops; pop the scoreboard on the done pulse
  task automatic waitDone(input string name, output int busyCycles, output int doneCount);
    int   guard;
    exp_t e;
    busyCycles = 0;
    doneCount  = 0;
    guard      = 0;
    while (busy && guard < 40) begin
      busyCycles++;
      if (done) begin
        doneCount++;
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          checkOutput({name, " count"}, int'(count), int'(e.count));
          checkOutput({name, " tc"}, int'(tc), int'(e.tc));
        end
      end
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) checkOutput({name, " timeout"}, 1, 0);
    if (doneCount == 0 && expQ.size() > 0) void'(expQ.pop_front());
  endtask

  // Issue one command through the handshake and follow it to completion
  task automatic applyStimulus(input string name, input logic [1:0] op, input logic [3:0] data,
                               output int busyCycles, output int doneCount);
    int waited;
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
    waited    = 0;
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) checkOutput({name, " ready timeout"}, 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    waitDone(name, busyCycles, doneCount);
  endtask

  initial begin
    int   bc;
    int   dc;
    exp_t e;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_LOAD;
    cmd_data  = 4'd5;

    vecs[0]  = '{OP_LOAD,  4'd7,  4'd7, 1'b0, 2,  1'b0};
    vecs[1]  = '{OP_LOAD,  4'd8,  4'd8, 1'b0, 2,  1'b0};
    vecs[2]  = '{OP_UP,    4'd3,  4'd1, 1'b0, 4,  1'b1};
    vecs[3]  = '{OP_LOAD,  4'd1,  4'd1, 1'b0, 2,  1'b1};
    vecs[4]  = '{OP_DOWN,  4'd2,  4'd9, 1'b1, 3,  1'b1};
    vecs[5]  = '{OP_LOAD,  4'd12, 4'd9, 1'b1, 2,  1'b1};
    vecs[6]  = '{OP_UP,    4'd0,  4'd9, 1'b1, 2,  1'b1};
    vecs[7]  = '{OP_CLEAR, 4'd0,  4'd0, 1'b0, 2,  1'b0};
    vecs[8]  = '{OP_DOWN,  4'd0,  4'd0, 1'b0, 2,  1'b0};
    vecs[9]  = '{OP_UP,    4'd15, 4'd5, 1'b0, 16, 1'b1};
    vecs[10] = '{OP_DOWN,  4'd7,  4'd8, 1'b0, 8,  1'b1};
    vecs[11] = '{OP_LOAD,  4'd15, 4'd9, 1'b1, 2,  1'b1};

    // Reset with a command already offered: nothing may be accepted
    #2 rst = 1'b0;
    cmd_valid = 1'b1;
    #1;
    checkOutput("reset cmd_ready", int'(cmd_ready), 1);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset count", int'(count), 0);
    checkOutput("reset tc", int'(tc), 0);
    @(negedge clk);
    checkOutput("reset edge busy", int'(busy), 0);
    checkOutput("reset edge count", int'(count), 0);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post reset ready", int'(cmd_ready), 1);

    // Table of commands with scoreboard-tracked final results
    for (int i = 0; i < 12; i++) begin
      e.count = vecs[i].expCount;
      e.tc    = vecs[i].expTc;
      expQ.push_back(e);
      applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, bc, dc);
      checkOutput($sformatf("vec%0d busy cycles", i), bc, vecs[i].expBusy);
      checkOutput($sformatf("vec%0d done pulses", i), dc, 1);
      checkOutput($sformatf("vec%0d ready back", i), int'(cmd_ready), 1);
`ifdef JK_SEQ_WRAP_FLAG_EN
      checkOutput($sformatf("vec%0d wrap_flag", i), int'(wrap_flag), int'(vecs[i].expWrap));
`endif
    end

    // Per-step view of UP 3 from 8: 9, 0, 1 on successive edges
    e.count = 4'd8;
    e.tc    = 1'b0;
    expQ.push_back(e);
    applyStimulus("seqB load", OP_LOAD, 4'd8, bc, dc);
    cmd_op    = OP_UP;
    cmd_data  = 4'd3;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("seqB exec count", int'(count), 8);
    checkOutput("seqB exec busy", int'(busy), 1);
    @(negedge clk);
    checkOutput("seqB step1 count", int'(count), 9);
    checkOutput("seqB step1 tc", int'(tc), 1);
    checkOutput("seqB step1 done", int'(done), 0);
    @(negedge clk);
    checkOutput("seqB step2 count", int'(count), 0);
    checkOutput("seqB step2 tc", int'(tc), 0);
`ifdef JK_SEQ_WRAP_FLAG_EN
    checkOutput("seqB wrap_flag", int'(wrap_flag), 1);
`endif
    @(negedge clk);
    checkOutput("seqB step3 count", int'(count), 1);
    checkOutput("seqB step3 done", int'(done), 1);
    @(negedge clk);
    checkOutput("seqB after done", int'(done), 0);
    checkOutput("seqB ready", int'(cmd_ready), 1);

    // Reset in the middle of UP 5, with the request still held
    e.count = 4'd0;
    e.tc    = 1'b0;
    expQ.push_back(e);
    applyStimulus("seqC clear", OP_CLEAR, 4'd0, bc, dc);
    cmd_op    = OP_UP;
    cmd_data  = 4'd5;
    cmd_valid = 1'b1;
    @(negedge clk);
    checkOutput("seqC exec count", int'(count), 0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("seqC two steps", int'(count), 2);
    #2 rst = 1'b0;
    #1;
    checkOutput("seqC async count", int'(count), 0);
    checkOutput("seqC async busy", int'(busy), 0);
    checkOutput("seqC async ready", int'(cmd_ready), 1);
    dc = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (done) dc++;
    end
    checkOutput("seqC no done in reset", dc, 0);
    checkOutput("seqC held count", int'(count), 0);
    rst = 1'b1;
    checkOutput("seqC release idle", int'(busy), 0);
    @(negedge clk);
    checkOutput("seqC held accepted", int'(busy), 1);
    cmd_valid = 1'b0;
    e.count = 4'd5;
    e.tc    = 1'b0;
    expQ.push_back(e);
    waitDone("seqC rerun", bc, dc);
    checkOutput("seqC rerun busy cycles", bc, 6);
    checkOutput("seqC rerun done pulses", dc, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jk_count_sequencer.md
JK_COUNT_SEQUENCER -- requirements
Module: jk_count_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the counter bit width.
REQ-002 SHALL have parameter MOD, default 10, the count modulus; legal range 2..2**WIDTH.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port cmd_valid  input  1  command present.
REQ-006 SHALL have port cmd_ready  output  1  sequencer can accept a command.
REQ-007 SHALL have port cmd_op  input  2  opcode: 00 CLEAR, 01 LOAD, 10 UP, 11 DOWN.
REQ-008 SHALL have port cmd_data  input  WIDTH  LOAD value, or step count n for UP/DOWN.
REQ-009 SHALL have port count  output  WIDTH  q outputs of the JK flop bank.
REQ-010 SHALL have port busy  output  1  high while a command executes.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a command completes.
REQ-012 SHALL have port tc  output  1  combinational terminal count: count==MOD-1.

Function
REQ-013 SHALL use FSM states IDLE, EXEC, DONE; cmd_ready=1 only in IDLE, and busy=1 in EXEC or DONE.
REQ-014 SHALL accept a command on a rising edge with cmd_valid&&cmd_ready, latching op and data, then move IDLE->EXEC.
REQ-015 SHALL leave cmd_valid unconsumed while busy; the requester holds it until cmd_ready.
REQ-016 SHALL drive the flop bank only through per-bit J/K; J=K=0 (hold) in IDLE and DONE.
REQ-017 CLEAR SHALL drive J=0,K=1 on all bits for one EXEC cycle, giving count=0, then move to DONE.
REQ-018 LOAD SHALL drive J=d,K=~d for one EXEC cycle, then move to DONE; d>=MOD saturates to MOD-1.
REQ-019 UP/DOWN SHALL step count by +1/-1 mod MOD once per EXEC cycle for n cycles, using toggle form J=K=count^next.
REQ-020 SHALL wrap UP from MOD-1 to 0, and DOWN from 0 to MOD-1.
REQ-021 SHALL leave EXEC for DONE on the edge that applies the nth step; n=0 spends one EXEC cycle with no step.
REQ-022 SHALL assert done exactly in the DONE cycle, then return to IDLE; back-to-back accept is possible on the next edge.
REQ-023 SHALL assert tc combinationally from count, independent of FSM state.

Reset
REQ-024 SHALL, on rst low, immediately force state=IDLE, count=0, and latched op/data=0, regardless of the clock or a command in flight.
REQ-025 SHALL hold cmd_ready=1, busy=0, done=0, and tc=(MOD==1?1:0)=0 during reset.
REQ-026 SHALL not accept a command on the first rising edge while rst is still low.

Configuration
REQ-027 SHALL add output wrap_flag (1 bit) when macro JK_SEQ_WRAP_FLAG_EN is defined; it is a sticky flag set by any UP/DOWN wrap and cleared by CLEAR or reset.
REQ-028 SHALL have no wrap_flag port and no flag logic when JK_SEQ_WRAP_FLAG_EN is undefined; all other behaviour is identical.

Structure
REQ-029 SHALL place the opcode constants (CLEAR/LOAD/UP/DOWN) and FSM state encodings in shared package jk_seq_pkg.
REQ-030 SHALL instantiate sub-module jk_bank: WIDTH behavioural JK flops with per-bit J/K in, q out, and the same clk/rst.
REQ-031 SHALL compute next-count and J/K derivation in the top level; jk_bank contains no sequencing logic.

Verification (WIDTH=4, MOD=10)
REQ-032 Reset release, then LOAD 7 -> count=7 two edges after accept, done pulses once, cmd_ready returns high.
REQ-033 Count 8 then UP n=3 -> count 9,0,1 on successive edges; tc=1 at 9; wrap_flag=1 if enabled.
REQ-034 Count 1 then DOWN n=2 -> count 0 then 9; done follows the final step; LOAD 12 -> count=9.
REQ-035 UP n=0 -> count unchanged; busy for 2 cycles; done pulses once.
REQ-036 rst low mid-UP n=5 after 2 steps -> count=0 and IDLE immediately, no done pulse; a held cmd_valid is accepted after release.
